// File: rtl/counter_pkg.sv
// Shared types for the modulo counter: overflow-mode and one-shot state encodings.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'd0,
        MODE_SAT     = 2'd1,
        MODE_ONESHOT = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

    typedef enum logic {
        ST_ARMED = 1'b0,
        ST_DONE  = 1'b1
    } state_e;

endpackage

// File: rtl/counter_step_calc.sv
// Combinational step evaluator: applies one up/down step against a runtime limit
// and reports the resulting value plus terminal/wrap/saturate/overflow indications.
module counter_step_calc
    import counter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STEP_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] value,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic [DATA_WIDTH-1:0] limit,
    input  logic                  dir_up,
    input  mode_e                 mode,
    output logic [DATA_WIDTH-1:0] next_value,
    output logic                  tc,
    output logic                  wrap,
    output logic                  sat,
    output logic                  ovf,
    output logic                  hit
);

    // One extra bit so limit = all-ones and limit + 1 never overflow.
    logic [DATA_WIDTH:0] v_x;
    logic [DATA_WIDTH:0] lim_x;
    logic [DATA_WIDTH:0] bound_x;
    logic [DATA_WIDTH:0] step_x;
    logic [DATA_WIDTH:0] s_x;
    logic [DATA_WIDTH:0] sum_x;
    logic [DATA_WIDTH:0] diff_x;
    logic                wrap_mode;

    assign v_x       = {1'b0, value};
    assign lim_x     = {1'b0, limit};
    assign bound_x   = lim_x + {{DATA_WIDTH{1'b0}}, 1'b1};
    assign step_x    = {{(DATA_WIDTH + 1 - STEP_WIDTH){1'b0}}, step};
    assign s_x       = (step_x > bound_x) ? bound_x : step_x;
    assign sum_x     = v_x + s_x;
    assign wrap_mode = (mode == MODE_WRAP) || (mode == MODE_RSVD);

    always_comb begin
        next_value = value;
        tc         = 1'b0;
        wrap       = 1'b0;
        sat        = 1'b0;
        ovf        = 1'b0;
        hit        = 1'b0;
        diff_x     = '0;
        if (dir_up) begin
            // A value already above a lowered limit lands here as an overflow.
            if (sum_x <= lim_x) begin
                next_value = sum_x[DATA_WIDTH-1:0];
                hit        = (sum_x == lim_x);
                tc         = hit;
            end else begin
                ovf = 1'b1;
                tc  = 1'b1;
                if (wrap_mode) begin
                    diff_x     = sum_x - bound_x;
                    next_value = diff_x[DATA_WIDTH-1:0];
                    wrap       = 1'b1;
                end else begin
                    next_value = limit;
                    sat        = (mode == MODE_SAT);
                end
            end
        end else if (v_x > lim_x) begin
            diff_x     = v_x - s_x;
            next_value = (diff_x > lim_x) ? limit : diff_x[DATA_WIDTH-1:0];
        end else if (s_x <= v_x) begin
            diff_x     = v_x - s_x;
            next_value = diff_x[DATA_WIDTH-1:0];
            hit        = (diff_x == '0);
            tc         = hit;
        end else begin
            ovf = 1'b1;
            tc  = 1'b1;
            if (wrap_mode) begin
                diff_x     = v_x + bound_x - s_x;
                next_value = diff_x[DATA_WIDTH-1:0];
                wrap       = 1'b1;
            end else begin
                next_value = '0;
                sat        = (mode == MODE_SAT);
            end
        end
    end

endmodule

// File: rtl/counter_mod_param.sv
// Up/down modulo counter with programmable step and limit, load/clear, and
// wrap / saturate / one-shot overflow handling with registered status pulses.
module counter_mod_param
    import counter_pkg::*;
#(
    parameter int unsigned               DATA_WIDTH  = 32,
    parameter int unsigned               STEP_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0]     RESET_VALUE = '0
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  en_i,
    input  logic                  dir_i,
    input  logic [STEP_WIDTH-1:0] step_i,
    input  logic [DATA_WIDTH-1:0] limit_i,
    input  logic [1:0]            mode_i,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] load_value_i,
    input  logic                  clear_i,
    output logic [DATA_WIDTH-1:0] value_o,
    output logic                  tc_o,
    output logic                  wrap_o,
    output logic                  sat_o,
    output logic                  done_o,
    output logic                  ovf_sticky_o
);

    mode_e                 mode;
    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] value_q, value_d;
    logic                  tc_q, tc_d;
    logic                  wrap_q, wrap_d;
    logic                  sat_q, sat_d;
    logic                  sticky_q, sticky_d;

    logic [DATA_WIDTH-1:0] calc_value;
    logic                  calc_tc, calc_wrap, calc_sat, calc_ovf, calc_hit;
    logic [DATA_WIDTH-1:0] clear_value;
    logic [DATA_WIDTH-1:0] load_value;
    logic                  step_active;

    assign mode        = mode_e'(mode_i);
    assign clear_value = (RESET_VALUE > limit_i) ? limit_i : RESET_VALUE;
    assign load_value  = (load_value_i > limit_i) ? limit_i : load_value_i;
    assign step_active = en_i && (state_q == ST_ARMED) && (step_i != '0);

    counter_step_calc #(
        .DATA_WIDTH (DATA_WIDTH),
        .STEP_WIDTH (STEP_WIDTH)
    ) u_step_calc (
        .value      (value_q),
        .step       (step_i),
        .limit      (limit_i),
        .dir_up     (dir_i),
        .mode       (mode),
        .next_value (calc_value),
        .tc         (calc_tc),
        .wrap       (calc_wrap),
        .sat        (calc_sat),
        .ovf        (calc_ovf),
        .hit        (calc_hit)
    );

    always_comb begin
        value_d  = value_q;
        state_d  = state_q;
        sticky_d = sticky_q;
        tc_d     = 1'b0;
        wrap_d   = 1'b0;
        sat_d    = 1'b0;
        if (clear_i) begin
            value_d  = clear_value;
            sticky_d = 1'b0;
            state_d  = ST_ARMED;
        end else if (load_i) begin
            value_d = load_value;
            state_d = ST_ARMED;
        end else if (step_active) begin
            value_d  = calc_value;
            tc_d     = calc_tc;
            wrap_d   = calc_wrap;
            sat_d    = calc_sat;
            sticky_d = sticky_q | calc_ovf;
            if ((mode == MODE_ONESHOT) && (calc_ovf || calc_hit)) begin
                state_d = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            value_q  <= RESET_VALUE;
            state_q  <= ST_ARMED;
            tc_q     <= 1'b0;
            wrap_q   <= 1'b0;
            sat_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            value_q  <= value_d;
            state_q  <= state_d;
            tc_q     <= tc_d;
            wrap_q   <= wrap_d;
            sat_q    <= sat_d;
            sticky_q <= sticky_d;
        end
    end

    assign value_o      = value_q;
    assign tc_o         = tc_q;
    assign wrap_o       = wrap_q;
    assign sat_o        = sat_q;
    assign done_o       = (state_q == ST_DONE);
    assign ovf_sticky_o = sticky_q;

endmodule

// File: tb/tb_counter_mod_param.sv
// Directed plus randomized bench for counter_mod_param against an integer-arithmetic model.
module tb_counter_mod_param;

    localparam int unsigned DW = 8;
    localparam int unsigned SW = 8;

    logic          clk_i = 1'b0;
    logic          rstn_i, en_i, dir_i, load_i, clear_i;
    logic [SW-1:0] step_i;
    logic [DW-1:0] limit_i, load_value_i;
    logic [1:0]    mode_i;
    logic [DW-1:0] value_o;
    logic          tc_o, wrap_o, sat_o, done_o, ovf_sticky_o;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state, plain integers
    int m_val;
    bit m_tc, m_wrap, m_sat, m_done, m_sticky;

    counter_mod_param #(
        .DATA_WIDTH  (DW),
        .STEP_WIDTH  (SW),
        .RESET_VALUE (8'd0)
    ) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .en_i         (en_i),
        .dir_i        (dir_i),
        .step_i       (step_i),
        .limit_i      (limit_i),
        .mode_i       (mode_i),
        .load_i       (load_i),
        .load_value_i (load_value_i),
        .clear_i      (clear_i),
        .value_o      (value_o),
        .tc_o         (tc_o),
        .wrap_o       (wrap_o),
        .sat_o        (sat_o),
        .done_o       (done_o),
        .ovf_sticky_o (ovf_sticky_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_value"}, int'(value_o), m_val);
        chk({tag, "_tc"}, int'(tc_o), int'(m_tc));
        chk({tag, "_wrap"}, int'(wrap_o), int'(m_wrap));
        chk({tag, "_sat"}, int'(sat_o), int'(m_sat));
        chk({tag, "_done"}, int'(done_o), int'(m_done));
        chk({tag, "_sticky"}, int'(ovf_sticky_o), int'(m_sticky));
    endtask

    // Reference behaviour for one clock edge, from the counter's rules.
    task automatic model_edge();
        int L, v, s, st, r;
        bit wrapm;
        L  = int'(limit_i);
        v  = m_val;
        st = int'(step_i);
        s  = (st > L + 1) ? L + 1 : st;
        wrapm = (mode_i == 2'd0) || (mode_i == 2'd3);
        if (!rstn_i) begin
            m_val = 0; m_tc = 0; m_wrap = 0; m_sat = 0; m_done = 0; m_sticky = 0;
        end else if (clear_i) begin
            m_val = (0 > L) ? L : 0;
            m_tc = 0; m_wrap = 0; m_sat = 0; m_done = 0; m_sticky = 0;
        end else if (load_i) begin
            r = int'(load_value_i);
            m_val = (r > L) ? L : r;
            m_tc = 0; m_wrap = 0; m_sat = 0; m_done = 0;
        end else begin
            m_tc = 0; m_wrap = 0; m_sat = 0;
            if (en_i && !m_done && st != 0) begin
                if (dir_i) begin
                    if (v + s <= L) begin
                        m_val = v + s;
                        m_tc  = (m_val == L);
                        if (m_tc && mode_i == 2'd2) m_done = 1;
                    end else begin
                        m_tc = 1; m_sticky = 1;
                        if (wrapm) begin m_val = v + s - (L + 1); m_wrap = 1; end
                        else if (mode_i == 2'd1) begin m_val = L; m_sat = 1; end
                        else begin m_val = L; m_done = 1; end
                    end
                end else if (v > L) begin
                    m_val = (v - s > L) ? L : v - s;
                end else if (s <= v) begin
                    m_val = v - s;
                    m_tc  = (m_val == 0);
                    if (m_tc && mode_i == 2'd2) m_done = 1;
                end else begin
                    m_tc = 1; m_sticky = 1;
                    if (wrapm) begin m_val = v + (L + 1) - s; m_wrap = 1; end
                    else if (mode_i == 2'd1) begin m_val = 0; m_sat = 1; end
                    else begin m_val = 0; m_done = 1; end
                end
            end
        end
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk_i);
        #1;
        check_all(tag);
    endtask

    initial begin
        rstn_i = 0; en_i = 0; dir_i = 1; load_i = 0; clear_i = 0;
        step_i = 0; limit_i = 8'd9; load_value_i = 0; mode_i = 2'd0;
        m_val = 0; m_tc = 0; m_wrap = 0; m_sat = 0; m_done = 0; m_sticky = 0;

        tick("reset");
        chk("reset_value_const", int'(value_o), 0);
        rstn_i = 1;

        // Wrap up: limit 9, step 3
        en_i = 1; step_i = 8'd3;
        tick("wrap1"); chk("wrap1_const", int'(value_o), 3);
        tick("wrap2"); chk("wrap2_const", int'(value_o), 6);
        tick("wrap3"); chk("wrap3_tc_const", int'(tc_o), 1);
        tick("wrap4"); chk("wrap4_const", int'(value_o), 2);
        chk("wrap4_wrap_const", int'(wrap_o), 1);
        chk("wrap4_sticky_const", int'(ovf_sticky_o), 1);
        tick("wrap5"); chk("wrap5_const", int'(value_o), 5);

        // Saturate down from 5 by 2
        en_i = 0; load_i = 1; load_value_i = 8'd5; mode_i = 2'd1;
        tick("sat_load");
        load_i = 0; en_i = 1; dir_i = 0; step_i = 8'd2;
        tick("sat1"); tick("sat2");
        tick("sat3"); chk("sat3_sat_const", int'(sat_o), 1);
        tick("sat4");
        en_i = 0; clear_i = 1;
        tick("sat_clear"); chk("sat_clear_sticky_const", int'(ovf_sticky_o), 0);
        clear_i = 0;

        // One-shot up to 4
        limit_i = 8'd4; step_i = 8'd1; dir_i = 1; mode_i = 2'd2; en_i = 1;
        for (int i = 0; i < 4; i++) tick("os_count");
        chk("os_done_const", int'(done_o), 1);
        for (int i = 0; i < 3; i++) tick("os_hold");
        load_i = 1; load_value_i = 8'd1;
        tick("os_load"); chk("os_load_done_const", int'(done_o), 0);
        load_i = 0;
        tick("os_resume");

        // Priority and clamping
        clear_i = 1; load_i = 1; en_i = 1;
        tick("prio");
        clear_i = 0; en_i = 0; limit_i = 8'd100; load_value_i = 8'd200;
        tick("clamp"); chk("clamp_const", int'(value_o), 100);
        load_i = 0;

        // Reset mid-count, then a low glitch between edges
        mode_i = 2'd0; en_i = 1; step_i = 8'd1;
        tick("pre_rst");
        rstn_i = 0;
        tick("mid_rst");
        rstn_i = 1;
        tick("post_rst");
        en_i = 0;
        #2 rstn_i = 0;
        #2 rstn_i = 1;
        check_all("glitch_between");
        tick("glitch_edge");

        // Large step and full-range limit
        limit_i = 8'd9; step_i = 8'd15; en_i = 1; dir_i = 1;
        tick("big1"); tick("big2");
        chk("big2_wrap_const", int'(wrap_o), 1);
        en_i = 0; limit_i = 8'd255; load_i = 1; load_value_i = 8'd254;
        tick("full_load");
        load_i = 0; en_i = 1; step_i = 8'd1;
        tick("full1"); chk("full1_const", int'(value_o), 255);
        tick("full2"); chk("full2_const", int'(value_o), 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rstn_i       = ($urandom_range(0, 49) != 0);
            clear_i      = ($urandom_range(0, 39) == 0);
            load_i       = ($urandom_range(0, 19) == 0);
            load_value_i = 8'($urandom);
            en_i         = ($urandom_range(0, 3) != 0);
            dir_i        = 1'($urandom);
            mode_i       = 2'($urandom);
            step_i       = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 4));
            if ($urandom_range(0, 29) == 0) begin
                case ($urandom_range(0, 2))
                    0:       limit_i = 8'($urandom_range(0, 20));
                    1:       limit_i = 8'd255;
                    default: limit_i = 8'($urandom);
                endcase
            end
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_mod_param.md
Name: counter_mod_param

Overview:
Parametrised up/down modulo counter: the next generation of the plain increment-only counter primitive. Adds programmable step, runtime limit, synchronous load and clear, and three overflow modes (wrap, saturate, one-shot). Registered terminal-count, wrap and saturation pulses, a sticky overflow flag and a one-shot done state. Lives in primitives/sequential; used for timers, address generators and event dividers.

Parameters:
DATA_WIDTH, 32, width of value, limit and load value
STEP_WIDTH, 8, width of step_i; must be <= DATA_WIDTH
RESET_VALUE, 0, value after reset or clear_i, clamped to limit_i on clear

Ports:
clk_i  in  1  clock, rising edge
rstn_i  in  1  reset, synchronous, active-low
en_i  in  1  count-step enable
dir_i  in  1  1 = up, 0 = down
step_i  in  STEP_WIDTH  increment or decrement amount per enabled cycle
limit_i  in  DATA_WIDTH  upper bound; count range is 0..limit_i inclusive
mode_i  in  2  0 = wrap, 1 = saturate, 2 = one-shot, 3 = reserved (behaves as wrap)
load_i  in  1  synchronous load of load_value_i
load_value_i  in  DATA_WIDTH  value to load, clamped to limit_i
clear_i  in  1  synchronous clear of value, flags and state
value_o  out  DATA_WIDTH  current count
tc_o  out  1  1-cycle pulse: step result reached or crossed the bound
wrap_o  out  1  1-cycle pulse: wrap-around occurred
sat_o  out  1  1-cycle pulse: result was clamped at a bound
done_o  out  1  level: one-shot finished
ovf_sticky_o  out  1  sticky: any overflow or underflow since the last clear or reset

Behaviour:
- Reset: one clock, one synchronous active-low reset. On a clk_i edge with rstn_i = 0: value_o = RESET_VALUE; all flags = 0; state = ARMED. rstn_i has no effect between edges.
- Priority per edge: reset > clear_i > load_i > count step.
- clear_i: value_o = min(RESET_VALUE, limit_i); tc_o, wrap_o, sat_o, done_o and ovf_sticky_o = 0; state = ARMED.
- load_i: value_o = min(load_value_i, limit_i); state = ARMED; ovf_sticky_o holds; pulses = 0.
- Count step: occurs when en_i = 1, state = ARMED and step_i != 0. Result is visible on value_o one cycle after en_i is sampled. If step_i = 0, value holds and no pulses fire.
- Effective step: s = min(step_i, limit_i + 1). Arithmetic is done in DATA_WIDTH+1 bits; limit_i = all-ones must not overflow.
- Up, v + s <= limit_i: result is v + s. tc_o fires if the result equals limit_i.
- Up, v + s > limit_i (overflow): tc_o = 1, ovf_sticky_o set.
  - wrap: result = v + s - (limit_i + 1); wrap_o = 1.
  - saturate: result = limit_i; sat_o = 1.
  - one-shot: result = limit_i; enter DONE.
- Down, s <= v: result is v - s. tc_o fires if the result is 0.
- Down, s > v (underflow): tc_o = 1, ovf_sticky_o set.
  - wrap: result = v + (limit_i + 1) - s; wrap_o = 1.
  - saturate: result = 0; sat_o = 1.
  - one-shot: result = 0; enter DONE.
- One-shot, exact arrival at the bound (no crossing): enter DONE and fire tc_o; ovf_sticky_o is not set.
- Limit lowered below the current value:
  - up step: treated as overflow.
  - down step: result = min(v - s, limit_i); no flags.
- State machine: ARMED -> DONE on a one-shot terminal event.
  - DONE -> ARMED only on clear_i or load_i.
  - In DONE, en_i is ignored and done_o = 1.
  - Changing mode_i while in DONE keeps DONE.
- Pulse outputs (tc_o, wrap_o, sat_o) are registered and high for exactly one cycle, aligned with the new value_o.

Decomposition:
- Package counter_pkg: mode enum (MODE_WRAP, MODE_SAT, MODE_ONESHOT, MODE_RSVD) and state enum (ST_ARMED, ST_DONE).
- One natural sub-module: counter_step_calc. It is combinational and maps (value, step, limit, dir, mode) to (next value, tc, wrap, sat, ovf, hit). The top level holds registers, priority logic and the FSM.

Test Plan:
1. Wrap up, DATA_WIDTH=8, limit=9, step=3, start 0, en held -> 3, 6, 9 (tc_o), 2 (tc_o, wrap_o, ovf_sticky_o=1), 5.
2. Saturate down: load 5, dir=0, step=2 -> 3, 1, 0 (sat_o, tc_o, ovf_sticky_o), 0 (sat_o again); clear_i -> ovf_sticky_o=0, value=0.
3. One-shot up: limit=4, step=1 from 0 -> 1, 2, 3, 4 (tc_o, done_o=1); 3 further en cycles -> holds 4, no pulses; load_i with 1 -> value 1, done_o=0, counting resumes.
4. Priority and clamping: clear_i+load_i+en_i in the same cycle -> RESET_VALUE with all flags 0. load_value_i=200 with limit=100 -> 100.
5. Reset: rstn_i=0 for one edge mid-count with en_i=1 -> value 0, all outputs 0, ARMED. rstn_i pulsed low between edges -> no output change.
6. Large step and limit edge: limit=9, step=15, wrap mode -> s=10, value holds, wrap_o pulses every step. limit=255, value 254, step 1 up -> 255 with tc_o, then 0 with wrap_o, no width overflow.
